// File: rtl/bcd_countdown.sv
// Registered packed-BCD down counter with IDLE/RUN run control, load validation
// and one-cycle expired / load_err pulses.
module bcd_countdown #(
   parameter int DIGITS = 3,
   parameter bit WRAP   = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  tick,
   output logic [4*DIGITS-1:0]   count,
   output logic                  zero,
   output logic                  running,
   output logic                  expired,
   output logic                  load_err
);

   localparam int W = 4 * DIGITS;
   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   count_q, count_d;
   logic           running_q, running_d;
   logic           expired_q, expired_d;
   logic           load_err_q, load_err_d;

   logic [DIGITS-1:0] digit_ok;
   logic [DIGITS-1:0] borrow;
   logic [W-1:0]      dec_val;
   logic              load_ok;
   logic              count_zero;

   assign borrow[0] = 1'b1;

   // Per-digit decrement: a digit only changes when every lower digit was 0.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] cur;
      assign cur          = count_q[4*gi +: 4];
      assign digit_ok[gi] = (load_val[4*gi +: 4] <= 4'd9);
      assign dec_val[4*gi +: 4] = !borrow[gi]   ? cur :
                                  (cur == 4'd0) ? 4'd9 : cur - 4'd1;
      if (gi < DIGITS - 1) begin : g_borrow
         assign borrow[gi+1] = borrow[gi] && (cur == 4'd0);
      end
   end

   assign load_ok    = &digit_ok;
   assign count_zero = (count_q == '0);

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      expired_d  = 1'b0;
      load_err_d = 1'b0;

      if (load) begin
         if (load_ok) begin
            count_d = load_val;
            state_d = IDLE;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (stop) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && (!count_zero || WRAP)) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               if (tick) begin
                  // Decrementing zero borrows through every digit, giving all-9s.
                  if (!count_zero || WRAP) begin
                     count_d = dec_val;
                  end
                  if (count_q == ONE) begin
                     expired_d = 1'b1;
                     if (!WRAP) begin
                        state_d = IDLE;
                     end
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      running_d = (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         count_q    <= '0;
         running_q  <= 1'b0;
         expired_q  <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         running_q  <= running_d;
         expired_q  <= expired_d;
         load_err_q <= load_err_d;
      end
   end

   assign count    = count_q;
   assign zero     = count_zero;
   assign running  = running_q;
   assign expired  = expired_q;
   assign load_err = load_err_q;

endmodule

// File: doc/bcd_countdown.md
Name: bcd_countdown

Overview:
- Registered N-digit packed-BCD down counter with a small run-control FSM.
- Decrements by one BCD count per qualified tick.
- Companion to the combinational BCD incrementer; used for countdown timers and display-driven down counters.
- Checks the BCD validity of loaded values and flags when the count expires.

Parameters:
- DIGITS, 3, number of BCD digits; count width is 4*DIGITS.
- WRAP, 0. When 0, the counter stops at zero. When 1, zero rolls over to all-9s and the counter keeps running.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- load  input  1  load load_val into count; abort any run.
- load_val  input  4*DIGITS  packed BCD value; digit i occupies bits [4i+3:4i].
- start  input  1  begin counting (IDLE only).
- stop  input  1  pause counting; count is held.
- tick  input  1  decrement qualifier (e.g. 1 Hz strobe); honoured only in RUN.
- count  output  4*DIGITS  current packed BCD value.
- zero  output  1  combinational: count == 0.
- running  output  1  registered: FSM is in RUN.
- expired  output  1  registered 1-cycle pulse on the 1->0 transition.
- load_err  output  1  registered 1-cycle pulse when a rejected load occurs.

Behaviour:
- All state updates on the rising edge of clk. Reset is synchronous and active-high.
- Reset values: count = 0, state = IDLE, running = 0, expired = 0, load_err = 0. Consequently zero = 1.
- Priority within a cycle: rst > load > stop > start > tick.
- FSM states: IDLE, RUN.
- IDLE transitions:
  - start with count != 0 -> RUN.
  - start with count == 0 -> RUN if WRAP=1; stays IDLE if WRAP=0.
  - tick is ignored.
- RUN transitions:
  - stop -> IDLE, count held.
  - tick -> count decrements.
  - start is ignored.
- Load:
  - Accepted in any state.
  - If every digit of load_val is <= 9: count <= load_val next cycle, state <= IDLE.
  - If any digit is > 9: count and state are unchanged, and load_err = 1 for exactly the next cycle.
  - A rejected load still blocks stop, start and tick in that cycle.
- Decrement (1-cycle latency):
  - Digit 0 is decremented.
  - A digit equal to 0 becomes 9 and borrows from the next digit.
  - Borrow ripples through all digits; result is always valid BCD. Examples: 0x200 -> 0x199, 0x100 -> 0x099.
- Reaching zero:
  - A tick in RUN with count == 1 sets count <= 0 and expired = 1 in the same cycle as count becomes 0.
  - WRAP=0: state -> IDLE.
  - WRAP=1: stays RUN.
- Tick in RUN with count == 0: only reachable with WRAP=1; count <= all-9s (e.g. 0x999), expired = 0.
- expired and load_err are never high for more than one consecutive cycle unless the triggering event repeats.
- running updates in the same cycle as the state register.
- Reset mid-run returns to the reset values in one cycle; no pending pulses survive it.
- Illegal count values cannot occur. Only validated loads and BCD decrements write count.

Test Plan:
- Load 0x280, start, 3 ticks -> count 0x27F never appears; sequence is 0x279, 0x278, 0x277; running = 1.
- Load 0x200, start, tick -> 0x199. Load 0x100, start, tick -> 0x099. Load 0x000 (WRAP=1), start, tick -> 0x999 with expired = 0.
- WRAP=0: load 0x002, start, 2 ticks -> 0x001 then 0x000 with expired pulsing 1 cycle; state IDLE, zero = 1; further ticks hold 0x000.
- Load 0x2A0 while count = 0x150 in RUN -> load_err pulses 1 cycle, count stays 0x150, state stays RUN. Then load 0x967 -> count 0x967, running = 0.
- Run at 0x050, assert stop+tick together -> count holds 0x050, running = 0. Assert load+start together -> load wins, state IDLE.
- Assert rst during RUN at 0x123 with tick high -> next cycle count = 0x000, running = 0, expired = 0, load_err = 0.
